// File: rtl/if_id_skid_reg.sv
// IF/ID boundary: two-entry skid buffer with decoded head fields for ID.
// Define IFID_PERF_CNT_EN to add the id_stall_cnt / id_bubble_cnt counters.
module if_id_skid_reg #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        id_stall,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [5:0]  id_op,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [15:0] id_imm16,
    output logic        id_ext_s
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0] id_stall_cnt,
    output logic [31:0] id_bubble_cnt
`endif
);

    logic [31:0] pc_q   [DEPTH];
    logic [31:0] inst_q [DEPTH];
    logic        head_q;
    logic [1:0]  count_q;
    logic        tail;
    logic        push;
    logic        pop;

    // Ready looks only at registered count, keeping id_stall off the IF path.
    assign if_ready = (count_q != 2'd2);
    assign id_valid = (count_q != 2'd0);
    assign push     = if_valid & if_ready;
    assign pop      = id_valid & ~id_stall;
    assign tail     = head_q ^ count_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= 32'h0;
                inst_q[i] <= RESET_INST;
            end
        end else if (flush) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                pc_q[tail]   <= if_pc;
                inst_q[tail] <= if_inst;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign id_pc    = pc_q[head_q];
    assign id_inst  = inst_q[head_q];
    assign id_op    = id_inst[31:26];
    assign id_rs    = id_inst[25:21];
    assign id_rt    = id_inst[20:16];
    assign id_rd    = id_inst[15:11];
    assign id_imm16 = id_inst[15:0];

    // Logical immediates are zero-extended; everything else sign-extends.
    always_comb begin
        id_ext_s = 1'b1;
        case (id_op)
            6'h0C, 6'h0D, 6'h0E: id_ext_s = 1'b0;
            default:             id_ext_s = 1'b1;
        endcase
    end

`ifdef IFID_PERF_CNT_EN
    // Cleared only by rst; flush leaves the statistics intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_stall_cnt  <= 32'h0;
            id_bubble_cnt <= 32'h0;
        end else begin
            if (id_valid && id_stall) begin
                id_stall_cnt <= id_stall_cnt + 32'h1;
            end
            if (!id_valid) begin
                id_bubble_cnt <= id_bubble_cnt + 32'h1;
            end
        end
    end
`else
    // Counters absent in this build.
`endif

endmodule
